// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_pkg (package)
//  Description : Shared definitions for the datapath countdown timer:
//                state codes, state enum and the default data width.
//  Ports       : none (package)
//  Config      : COUNTDOWN_AUTO_RELOAD_EN (used by countdown_timer)
//  Revision    : 1.0  initial release
// ============================================================================
package dp_pkg;

   localparam int DATAWIDTH_DEFAULT = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // 2'b11 is deliberately left unnamed; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cnt_dec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_dec_unit
//  Description : Combinational decrement unit for the countdown timer.
//                Produces q-1 and a flag that q is exactly 1 (last step).
//  Ports       : q     in   DATAWIDTH  current count
//                dec   out  DATAWIDTH  q - 1 (only meaningful for q != 0)
//                last  out  1          q == 1
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_dec_unit
   import dp_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic [DATAWIDTH-1:0] q,
   output logic [DATAWIDTH-1:0] dec,
   output logic                 last
);

   localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

   assign dec  = q - ONE;
   assign last = (q == ONE);

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable down-counter with valid/ready load handshake,
//                count enable, abort and a one-cycle registered done pulse.
//  Ports       : Clk       in   1          rising-edge clock
//                Rst       in   1          synchronous reset, active-high
//                ld_valid  in   1          start value offered
//                ld_data   in   DATAWIDTH  start value, unsigned
//                ld_ready  out  1          load accepted (IDLE only)
//                en        in   1          count enable (pauses RUN when 0)
//                abort     in   1          cancel the running count
//                q         out  DATAWIDTH  current count, registered
//                busy      out  1          count in progress (RUN)
//                done      out  1          one-cycle expiry pulse
//  Config      : `define COUNTDOWN_AUTO_RELOAD_EN to make the count repeat
//                from the last loaded value instead of stopping.
//  Revision    : 1.0  initial release
// ============================================================================
module countdown_timer
   import dp_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 ld_valid,
   input  logic [DATAWIDTH-1:0] ld_data,
   output logic                 ld_ready,
   input  logic                 en,
   input  logic                 abort,
   output logic [DATAWIDTH-1:0] q,
   output logic                 busy,
   output logic                 done
);

   localparam logic [DATAWIDTH-1:0] ZERO = '0;

   state_t               state;
   logic [DATAWIDTH-1:0] dec_val;
   logic                 last;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [DATAWIDTH-1:0] reload;
`endif

   cnt_dec_unit #(
      .DATAWIDTH (DATAWIDTH)
   ) u_dec (
      .q    (q),
      .dec  (dec_val),
      .last (last)
   );

   // Outputs are registered alongside the state so each one reflects the
   // state being entered on this edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= S_IDLE;
         q        <= ZERO;
         busy     <= 1'b0;
         done     <= 1'b0;
         ld_ready <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload   <= ZERO;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // ld_ready is 1 throughout IDLE, so ld_valid alone completes
               // the handshake. en and abort have no effect here.
               if (ld_valid) begin
                  q <= ld_data;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  reload <= ld_data;
`endif
                  ld_ready <= 1'b0;
                  if (ld_data == ZERO) begin
                     // Zero-length count still produces its done pulse.
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  done <= 1'b0;
               end
            end

            S_RUN: begin
               if (abort) begin
                  // q keeps the value reached at the moment of the abort.
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b0;
                  ld_ready <= 1'b1;
               end else if (en && last) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  // Restart from the captured load value without leaving RUN.
                  // reload is never 0 here: a zero load never enters RUN.
                  q    <= reload;
                  done <= 1'b1;
`else
                  q     <= ZERO;
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
`endif
               end else if (en) begin
                  // last covers q==1 and RUN never holds q==0, so this
                  // decrement can never wrap.
                  q    <= dec_val;
                  done <= 1'b0;
               end else begin
                  done <= 1'b0;
               end
            end

            S_DONE: begin
               q        <= ZERO;
               state    <= S_IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               ld_ready <= 1'b1;
            end

            default: begin
               // Unused encoding 2'b11.
               q        <= ZERO;
               state    <= S_IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               ld_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer. A table of
//                per-cycle input/expected-output records drives the main
//                scenarios; a hand-written loop covers the full-range count.
//  Config      : COUNTDOWN_AUTO_RELOAD_EN selects the auto-reload table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

   logic       Clk;
   logic       Rst;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic       en;
   logic       abort;
   logic [7:0] q;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       rst;
      logic       ld_valid;
      logic [7:0] ld_data;
      logic       en;
      logic       abort;
      logic [7:0] q;
      logic       busy;
      logic       done;
      logic       ld_ready;
   } vec_t;

   vec_t vecs[$];

   countdown_timer #(
      .DATAWIDTH (8)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .en       (en),
      .abort    (abort),
      .q        (q),
      .busy     (busy),
      .done     (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic vec_t mk(input logic r, input logic lv, input logic [7:0] ld,
                               input logic e, input logic ab, input logic [7:0] eq,
                               input logic eb, input logic ed, input logic er);
      vec_t v;
      v.rst = r; v.ld_valid = lv; v.ld_data = ld; v.en = e; v.abort = ab;
      v.q = eq; v.busy = eb; v.done = ed; v.ld_ready = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got q=%0d busy=%b done=%b ld_ready=%b, want q=%0d busy=%b done=%b ld_ready=%b",
                  name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Drive inputs, let one rising edge happen, then sample 1 time unit later.
   task automatic step(input logic r, input logic lv, input logic [7:0] ld,
                       input logic e, input logic ab);
      Rst = r; ld_valid = lv; ld_data = ld; en = e; abort = ab;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst = 1'b1; ld_valid = 1'b0; ld_data = '0; en = 1'b0; abort = 1'b0;
      #2;

      //                 rst lv  data en ab |  q  busy done rdy
      vecs.push_back(mk(1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 1));   // reset
      vecs.push_back(mk(1, 1, 8'd7, 1, 1, 8'd0, 0, 0, 1));   // reset beats everything
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      // Load 5, en high: 5,4,3,2,1,0 with done on the 5th edge after load.
      vecs.push_back(mk(0, 1, 8'd5, 1, 0, 8'd5, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'd77,1, 0, 8'd4, 1, 0, 0));   // load refused in RUN
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 1, 0));   // DONE
      vecs.push_back(mk(0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 1));   // IDLE, abort ignored in DONE
      // Load 4 with en low two cycles: done two cycles later than without pauses.
      vecs.push_back(mk(0, 1, 8'd4, 1, 0, 8'd4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 0, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'd9, 0, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 1));
      // en/abort ignored in IDLE.
      vecs.push_back(mk(0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 1));
      // Zero load: done next cycle, never RUN.
      vecs.push_back(mk(0, 1, 8'd0, 1, 0, 8'd0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));
      // Load 9, abort at q=6: IDLE, q holds 6, no done.
      vecs.push_back(mk(0, 1, 8'd9, 1, 0, 8'd9, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd8, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd7, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd6, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 1, 8'd6, 0, 0, 1));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd6, 0, 0, 1));
      // Load 5, Rst at q=3.
      vecs.push_back(mk(0, 1, 8'd5, 1, 0, 8'd5, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));
      // Load 1: done on the very next edge.
      vecs.push_back(mk(0, 1, 8'd1, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));
`else
      // Load 3 with auto-reload: 3,2,1,3(done),2,1,3(done),2 then abort.
      vecs.push_back(mk(0, 1, 8'd3, 1, 0, 8'd3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'd9, 1, 0, 8'd3, 1, 1, 0));   // reload, load refused
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 0, 0, 8'd2, 1, 0, 0));   // pause
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd3, 1, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 1, 8'd2, 0, 0, 1));   // abort
      // Zero load still passes through DONE.
      vecs.push_back(mk(0, 1, 8'd0, 1, 0, 8'd0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));
      // Load 1: reloads 1 every edge, done each cycle.
      vecs.push_back(mk(0, 1, 8'd1, 1, 0, 8'd1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 8'd0, 1, 0, 8'd1, 1, 1, 0));
      vecs.push_back(mk(1, 0, 8'd0, 1, 0, 8'd0, 0, 0, 1));   // Rst mid-count
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].ld_valid, vecs[i].ld_data, vecs[i].en, vecs[i].abort);
         check($sformatf("vec%0d", i), {q, busy, done, ld_ready},
               {vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].ld_ready});
      end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
      // Full-range count: load 255, done exactly on the 255th edge after load.
      step(0, 1, 8'd255, 1, 0);
      check("full_load", {q, busy, done, ld_ready}, {8'd255, 1'b1, 1'b0, 1'b0});
      for (int k = 1; k < 255; k++) begin
         step(0, 0, 8'd0, 1, 0);
         check($sformatf("full_q%0d", k), {q, busy, done, ld_ready},
               {8'(255 - k), 1'b1, 1'b0, 1'b0});
      end
      step(0, 0, 8'd0, 1, 0);
      check("full_done", {q, busy, done, ld_ready}, {8'd0, 1'b0, 1'b1, 1'b0});
      step(0, 0, 8'd0, 1, 0);
      check("full_idle", {q, busy, done, ld_ready}, {8'd0, 1'b0, 1'b0, 1'b1});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
